// File: rtl/ex_fifo_pkg.sv
// Shared defaults and constant helpers for the ex_sync_fifo family.
package ex_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 256;
    localparam int DEF_AE_LVL = 4;

    // Ceiling log2 usable in parameter and port-width expressions.
    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/ex_fifo_ram.sv
// Dual-port word store: synchronous write, synchronous (FWFT=0) or
// asynchronous (FWFT=1) read.
module ex_fifo_ram
    import ex_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int FWFT   = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     w_en,
    input  logic [clog2(DEPTH)-1:0]  w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic                     r_en,
    input  logic [clog2(DEPTH)-1:0]  r_addr,
    output logic [DATA_W-1:0]        r_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array is deliberately left unreset so it maps onto RAM
    // macros; only the read-output register below carries a reset.
    always_ff @(posedge clk) begin
        if (w_en) begin
            mem[w_addr] <= w_data;
        end
    end

    if (FWFT != 0) begin : g_async_rd
        logic unused_ctrl;
        assign unused_ctrl = rst ^ r_en;
        assign r_data      = mem[r_addr];
    end else begin : g_sync_rd
        // NOTE: sequential state is always assigned with <= so every
        // register samples the pre-edge values of its neighbours.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_data <= '0;
            end else if (r_en) begin
                r_data <= mem[r_addr];
            end
        end
    end

endmodule

// File: rtl/ex_sync_fifo.sv
// Single-clock FIFO with registered count/status flags, overflow/underflow
// pulses and optional first-word-fall-through read port.
module ex_sync_fifo
    import ex_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 4,
    parameter int AE_LVL = DEF_AE_LVL,
    parameter int FWFT   = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [DATA_W-1:0]       w_data,
    output logic                    w_full,
    output logic                    w_afull,
    input  logic                    r_en,
    output logic [DATA_W-1:0]       r_data,
    output logic                    r_valid,
    output logic                    r_empty,
    output logic                    r_aempty,
    output logic [clog2(DEPTH):0]   count,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int AW = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW+1)'(AF_LVL);
    localparam logic [AW:0] AE_CNT   = (AW+1)'(AE_LVL);

    logic [AW:0]       wr_ptr, rd_ptr;
    logic [AW:0]       wr_ptr_nxt, rd_ptr_nxt, cnt_nxt;
    logic              wr_acc, rd_acc;
    logic [DATA_W-1:0] ram_q;

    // Acceptance uses the registered flags, so a full FIFO still pops and an
    // empty FIFO still pushes when both requests arrive together.
    assign wr_acc = w_en && !w_full  && !rst;
    assign rd_acc = r_en && !r_empty && !rst;

    assign wr_ptr_nxt = wr_ptr + (AW+1)'(wr_acc);
    assign rd_ptr_nxt = rd_ptr + (AW+1)'(rd_acc);

    // Pointers carry one extra wrap bit, so their difference spans 0..DEPTH.
    assign cnt_nxt = wr_ptr_nxt - rd_ptr_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            w_full    <= 1'b0;
            w_afull   <= 1'b0;
            r_empty   <= 1'b1;
            r_aempty  <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= cnt_nxt;
            w_full    <= (cnt_nxt == FULL_CNT);
            w_afull   <= (cnt_nxt >= AF_CNT);
            r_empty   <= (cnt_nxt == '0);
            r_aempty  <= (cnt_nxt <= AE_CNT);
            overflow  <= w_en && w_full;
            underflow <= r_en && r_empty;
        end
    end

    ex_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .FWFT   (FWFT)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .w_en   (wr_acc),
        .w_addr (wr_ptr[AW-1:0]),
        .w_data (w_data),
        .r_en   (rd_acc),
        .r_addr (rd_ptr[AW-1:0]),
        .r_data (ram_q)
    );

    if (FWFT != 0) begin : g_fwft
        // Head word is visible whenever the FIFO holds data; zero otherwise.
        assign r_valid = !r_empty;
        assign r_data  = r_valid ? ram_q : '0;
    end else begin : g_std
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= rd_acc;
            end
        end
        assign r_data = ram_q;
    end

endmodule

// File: tb/tb_ex_sync_fifo.sv
// Scoreboard bench: a standard-read and an FWFT instance share stimulus and
// are checked against a queue-based reference model.
module tb_ex_sync_fifo;

    localparam int DEPTH = 256;

    logic       clk, rst, w_en, r_en;
    logic [7:0] w_data;

    logic       w_full_0, w_afull_0, r_valid_0, r_empty_0, r_aempty_0, overflow_0, underflow_0;
    logic [7:0] r_data_0;
    logic [8:0] count_0;
    logic       w_full_1, w_afull_1, r_valid_1, r_empty_1, r_aempty_1, overflow_1, underflow_1;
    logic [7:0] r_data_1;
    logic [8:0] count_1;

    ex_sync_fifo #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data),
        .w_full(w_full_0), .w_afull(w_afull_0), .r_en(r_en), .r_data(r_data_0),
        .r_valid(r_valid_0), .r_empty(r_empty_0), .r_aempty(r_aempty_0),
        .count(count_0), .overflow(overflow_0), .underflow(underflow_0)
    );

    ex_sync_fifo #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .w_en(w_en), .w_data(w_data),
        .w_full(w_full_1), .w_afull(w_afull_1), .r_en(r_en), .r_data(r_data_1),
        .r_valid(r_valid_1), .r_empty(r_empty_1), .r_aempty(r_aempty_1),
        .count(count_1), .overflow(overflow_1), .underflow(underflow_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state, written only by the stimulus side.
    logic [7:0] m_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] exp_hold;
    logic       exp_rvalid, exp_ovf, exp_udf;
    bit         checking;

    int n_cmp, n_fail;
    int ovf_seen, udf_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Spec-level FIFO behaviour: acceptance decided by occupancy before the edge.
    task automatic model_step(input logic we, input logic [7:0] wd, input logic re, input logic rs);
        int sz;
        sz = m_q.size();
        if (rs) begin
            m_q.delete();
            exp_q.delete();
            exp_hold   = 8'h00;
            exp_rvalid = 1'b0;
            exp_ovf    = 1'b0;
            exp_udf    = 1'b0;
        end else begin
            exp_ovf    = we && (sz == DEPTH);
            exp_udf    = re && (sz == 0);
            exp_rvalid = re && (sz > 0);
            if (re && sz > 0) begin
                exp_hold = m_q.pop_front();
                exp_q.push_back(exp_hold);
            end
            if (we && sz < DEPTH) m_q.push_back(wd);
        end
    endtask

    task automatic cycle(input logic we, input logic [7:0] wd, input logic re, input logic rs = 1'b0);
        w_en = we; w_data = wd; r_en = re; rst = rs;
        @(posedge clk);
        model_step(we, wd, re, rs);
        #1;
    endtask

    // Monitor: compares both DUTs against the model on the falling edge.
    always @(negedge clk) begin
        if (checking) begin
            int sz;
            logic [7:0] d;
            sz = m_q.size();
            check("count0",    32'(count_0),    32'(sz));
            check("w_full0",   32'(w_full_0),   32'(sz == DEPTH));
            check("w_afull0",  32'(w_afull_0),  32'(sz >= DEPTH - 4));
            check("r_empty0",  32'(r_empty_0),  32'(sz == 0));
            check("r_aempty0", 32'(r_aempty_0), 32'(sz <= 4));
            check("overflow0", 32'(overflow_0), 32'(exp_ovf));
            check("underflow0",32'(underflow_0),32'(exp_udf));
            check("r_valid0",  32'(r_valid_0),  32'(exp_rvalid));
            if (r_valid_0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL r_data0: got %0h with no word expected at %0t", r_data_0, $time);
                end else begin
                    d = exp_q.pop_front();
                    check("r_data0", 32'(r_data_0), 32'(d));
                end
            end else begin
                check("r_data0_hold", 32'(r_data_0), 32'(exp_hold));
            end
            check("count1",    32'(count_1),    32'(sz));
            check("r_valid1",  32'(r_valid_1),  32'(sz != 0));
            check("overflow1", 32'(overflow_1), 32'(exp_ovf));
            check("underflow1",32'(underflow_1),32'(exp_udf));
            if (sz != 0) check("r_data1_head", 32'(r_data_1), 32'(m_q[0]));
            ovf_seen += int'(overflow_0);
            udf_seen += int'(underflow_0);
        end
    end

    initial begin
        int o0, u0;
        logic [7:0] d;
        n_cmp = 0; n_fail = 0; ovf_seen = 0; udf_seen = 0;
        checking = 0;
        w_en = 0; r_en = 0; w_data = 0; rst = 1;
        cycle(0, 8'h00, 0, 1);
        cycle(1, 8'h11, 1, 1);
        checking = 1;

        check("rst_count",   32'(count_0),   0);
        check("rst_r_empty", 32'(r_empty_0), 1);
        check("rst_r_aempty",32'(r_aempty_0),1);
        check("rst_w_full",  32'(w_full_0),  0);
        check("rst_w_afull", 32'(w_afull_0), 0);
        check("rst_r_valid", 32'(r_valid_0), 0);
        check("rst_r_data",  32'(r_data_0),  0);
        check("rst_ovf_udf", 32'({overflow_0, underflow_0}), 0);

        // Fill past capacity: 256 accepted, two rejected writes.
        o0 = ovf_seen;
        for (int i = 0; i < 258; i++) begin
            cycle(1, 8'(i), 0);
            if (i == 254) check("not_full_at_255", 32'(w_full_0), 0);
            if (i == 255) check("full_at_256",     32'(w_full_0), 1);
        end
        cycle(0, 8'h00, 0);
        check("fill_ovf_pulses", 32'(ovf_seen - o0), 2);
        check("fill_count",      32'(count_0), 256);

        // Drain with one extra read.
        u0 = udf_seen;
        for (int i = 0; i < 257; i++) cycle(0, 8'h00, 1);
        cycle(0, 8'h00, 0);
        check("drain_udf_pulses", 32'(udf_seen - u0), 1);
        check("drain_count",      32'(count_0), 0);
        check("drain_r_empty",    32'(r_empty_0), 1);
        check("drain_last_word",  32'(r_data_0), 8'hFF);

        // Steady state at 100 words with simultaneous push/pop.
        for (int i = 0; i < 100; i++) cycle(1, 8'($urandom), 0);
        for (int i = 0; i < 50; i++) cycle(1, 8'($urandom), 1);
        check("simul_count", 32'(count_0), 100);
        for (int i = 0; i < 101; i++) cycle(0, 8'h00, 1);

        // Threshold edges.
        for (int i = 0; i < 251; i++) cycle(1, 8'($urandom), 0);
        check("afull_251", 32'(w_afull_0), 0);
        cycle(1, 8'($urandom), 0);
        check("afull_252", 32'(w_afull_0), 1);
        for (int i = 0; i < 247; i++) cycle(0, 8'h00, 1);
        check("aempty_5", 32'(r_aempty_0), 0);
        cycle(0, 8'h00, 1);
        check("aempty_4", 32'(r_aempty_0), 1);
        for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);

        // Reset mid-operation at 37 words; requests during reset are ignored.
        for (int i = 0; i < 37; i++) cycle(1, 8'($urandom), 0);
        check("pre_rst_count", 32'(count_0), 37);
        cycle(1, 8'hEE, 1, 1);
        check("post_rst_count",   32'(count_0),   0);
        check("post_rst_r_empty", 32'(r_empty_0), 1);
        check("post_rst_r_valid", 32'(r_valid_0), 0);
        check("post_rst_fwft_valid", 32'(r_valid_1), 0);
        cycle(1, 8'h3C, 0);
        cycle(0, 8'h00, 1);
        check("post_rst_word", 32'(r_data_0), 8'h3C);
        check("post_rst_empty_again", 32'(r_empty_0), 1);

        // FWFT: word appears one cycle after the write, without r_en.
        cycle(0, 8'h00, 0, 1);
        cycle(1, 8'hA5, 0);
        check("fwft_r_data",  32'(r_data_1),  8'hA5);
        check("fwft_r_valid", 32'(r_valid_1), 1);
        check("std_no_valid", 32'(r_valid_0), 0);

        // Randomised traffic with varying fill bias and occasional resets.
        for (int p = 0; p < 6; p++) begin
            int wp;
            wp = (p % 3 == 0) ? 80 : ((p % 3 == 1) ? 20 : 50);
            for (int i = 0; i < 500; i++) begin
                cycle(logic'($urandom_range(0, 99) < wp), 8'($urandom),
                      logic'($urandom_range(0, 99) < 100 - wp),
                      logic'($urandom_range(0, 499) == 0));
            end
        end
        cycle(0, 8'h00, 0);
        cycle(0, 8'h00, 0);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_sync_fifo.md
EX_SYNC_FIFO -- requirements
Module: ex_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 256: word capacity; power of two, >= 4.
REQ-003 SHALL have parameter AF_LVL, default DEPTH-4: almost-full threshold in words.
REQ-004 SHALL have parameter AE_LVL, default 4: almost-empty threshold in words.
REQ-005 SHALL have parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-006 SHALL have port clk, input, 1: the single clock. Reset is synchronous and active-high.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port w_en, input, 1: write request.
REQ-009 SHALL have port w_data, input, DATA_W: write word.
REQ-010 SHALL have port w_full, output, 1: count == DEPTH.
REQ-011 SHALL have port w_afull, output, 1: count >= AF_LVL.
REQ-012 SHALL have port r_en, input, 1: read request (FWFT=1: pop acknowledge).
REQ-013 SHALL have port r_data, output, DATA_W: read word.
REQ-014 SHALL have port r_valid, output, 1: r_data holds a popped or presented word.
REQ-015 SHALL have port r_empty, output, 1: count == 0.
REQ-016 SHALL have port r_aempty, output, 1: count <= AE_LVL.
REQ-017 SHALL have port count, output, log2(DEPTH)+1: words stored.
REQ-018 SHALL have port overflow, output, 1: one-cycle pulse on a rejected write.
REQ-019 SHALL have port underflow, output, 1: one-cycle pulse on a rejected read.

Function
REQ-020 SHALL accept a write when w_en && !w_full, sampled at the rising edge of clk; the word is stored at wr_ptr and wr_ptr increments.
REQ-021 SHALL accept a read when r_en && !r_empty; rd_ptr increments.
REQ-022 SHALL use pointers of log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; the address is the low log2(DEPTH) bits.
REQ-023 SHALL update count, w_full, w_afull, r_empty and r_aempty registered, one cycle after the accepted operation: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 SHALL, with w_full=1 and w_en && r_en in the same cycle, accept the read, reject the write and pulse overflow.
REQ-025 SHALL, with r_empty=1 and w_en && r_en in the same cycle, accept the write, reject the read and pulse underflow.
REQ-026 SHALL, for FWFT=0, register r_data and pulse r_valid one cycle after an accepted read, and hold r_data otherwise.
REQ-027 SHALL, for FWFT=1, present the head word on r_data with r_valid = !r_empty; r_valid rises one cycle after the first write into an empty FIFO.
REQ-028 SHALL guarantee that the status flags and count are never X after reset, and that memory contents are never corrupted by rejected operations.

Reset
REQ-029 SHALL, while rst=1 at a clk edge, clear wr_ptr, rd_ptr and count to 0; set r_empty=1 and r_aempty=1; clear w_full, w_afull, r_valid, overflow and underflow to 0; and clear r_data to 0.
REQ-030 SHALL ignore w_en and r_en during reset, discard stored words on reset mid-operation, and leave the memory array unreset.

Structure
REQ-031 SHALL take default widths, depth and a clog2 constant function from shared package ex_fifo_pkg.
REQ-032 SHALL instantiate one sub-module, ex_fifo_ram: dual-port array with synchronous write, synchronous read for FWFT=0 and asynchronous read for FWFT=1.

Verification
REQ-033 SHALL cover: DEPTH=256, write 0..257 consecutively -> 256 words accepted, w_full=1 from cycle 257, two overflow pulses, count=256.
REQ-034 SHALL cover: from full, 257 reads -> r_data 0..255 in order with r_valid, r_empty=1 and count=0 afterward, one underflow pulse.
REQ-035 SHALL cover: count=100, simultaneous w_en and r_en for 50 cycles -> count stays 100 and data order is preserved.
REQ-036 SHALL cover thresholds: fill to 251 -> w_afull=0; fill to 252 -> w_afull=1; drain to 5 -> r_aempty=0; drain to 4 -> r_aempty=1.
REQ-037 SHALL cover: FWFT=1, single write of 8'hA5 into an empty FIFO -> r_data=8'hA5 and r_valid=1 one cycle later, before any r_en.
REQ-038 SHALL cover: rst=1 asserted at count=37 -> next cycle count=0, r_empty=1, r_valid=0, and the next write/read returns the new word only.
